// File: rtl/clock_sequencer.sv
// clock_sequencer: 1 ms timebase, RUN carry cascade and SET-mode field editing with auto-repeat and blink
module clock_sequencer #(
    parameter int TICK_DIV     = 50000,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int BLINK_HALF   = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_set,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_ms_carryup,
    input  logic       i_sec_carryup,
    input  logic       i_min_carryup,
    output logic       o_ms_up,
    output logic       o_ms_down,
    output logic       o_sec_up,
    output logic       o_sec_down,
    output logic       o_min_up,
    output logic       o_min_down,
    output logic       o_hr_up,
    output logic       o_hr_down,
    output logic       o_set_mode,
    output logic [1:0] o_field,
    output logic       o_blink
);
    typedef enum logic {RUN, SET} state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t          state, state_n;
    logic [PW-1:0]   pre, pre_n;
    logic [4:0]      hist;
    logic            rst_q;
    logic            ms_up_q, ms_up_n;
    logic [1:0]      field, field_n;
    logic            blink, blink_n;
    logic [BW-1:0]   blink_cnt, blink_cnt_n;
    logic            rep_act, rep_act_n;
    logic            rep_dir, rep_dir_n;
    logic            rep_rpt, rep_rpt_n;
    logic [RW-1:0]   rep_cnt, rep_cnt_n;
    logic [2:0]      up_q, up_n, down_q, down_n;
    logic            fire_up, fire_dn;
    logic [4:0]      btn, press;
    logic            set_p, up_p, down_p, left_p, right_p;
    logic            tick, run, live, move, rep_last, blink_last;
    logic [2:0]      sel;

    assign btn        = {i_set, i_up, i_down, i_left, i_right};
    assign press      = btn & ~hist;
    assign {set_p, up_p, down_p, left_p, right_p} = press;
    assign tick       = pre == PRE_LAST;
    assign run        = state == RUN;
    assign move       = left_p ^ right_p;
    assign rep_last   = rep_rpt ? rep_cnt == RATE_LAST : rep_cnt == DELAY_LAST;
    assign blink_last = blink_cnt == BLINK_LAST;
    assign sel        = 3'b001 << field;
    assign live       = ~i_rst & ~rst_q;

    // next-state, prescaler, cursor, blink and auto-repeat decisions
    always_comb begin
        state_n     = set_p ? (run ? SET : RUN) : state;
        pre_n       = (set_p || tick) ? '0 : pre + PW'(1);
        ms_up_n     = run && tick && !set_p;
        field_n     = field;
        blink_n     = blink;
        blink_cnt_n = blink_cnt;
        rep_act_n   = rep_act;
        rep_dir_n   = rep_dir;
        rep_rpt_n   = rep_rpt;
        rep_cnt_n   = rep_cnt;
        fire_up     = 1'b0;
        fire_dn     = 1'b0;
        if (set_p) begin
            field_n     = run ? 2'd0 : field;
            blink_n     = run;
            blink_cnt_n = '0;
            rep_act_n   = 1'b0;
        end else if (!run) begin
            if (tick) begin
                blink_cnt_n = blink_last ? '0 : blink_cnt + BW'(1);
                blink_n     = blink ^ blink_last;
            end
            if (move) begin
                field_n   = right_p ? (field == 2'd2 ? 2'd0 : field + 2'd1)
                                    : (field == 2'd0 ? 2'd2 : field - 2'd1);
                rep_act_n = 1'b0;
            end else if (i_up && i_down) begin
                rep_act_n = 1'b0;
            end else if (up_p || down_p) begin
                fire_up   = up_p;
                fire_dn   = down_p;
                rep_act_n = 1'b1;
                rep_dir_n = up_p;
                rep_rpt_n = 1'b0;
                rep_cnt_n = '0;
            end else if (rep_act && !(rep_dir ? i_up : i_down)) begin
                rep_act_n = 1'b0;
            end else if (rep_act && tick) begin
                rep_cnt_n = rep_last ? '0 : rep_cnt + RW'(1);
                rep_rpt_n = rep_rpt | rep_last;
                fire_up   = rep_last & rep_dir;
                fire_dn   = rep_last & ~rep_dir;
            end
        end
        up_n   = fire_up ? sel : 3'b000;
        down_n = fire_dn ? sel : 3'b000;
    end

    // state register with synchronous reset; button history loads 1 so held buttons are not presses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            pre       <= '0;
            hist      <= '1;
            rst_q     <= 1'b1;
            ms_up_q   <= 1'b0;
            field     <= 2'd0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            rep_act   <= 1'b0;
            rep_dir   <= 1'b0;
            rep_rpt   <= 1'b0;
            rep_cnt   <= '0;
            up_q      <= 3'b000;
            down_q    <= 3'b000;
        end else begin
            state     <= state_n;
            pre       <= pre_n;
            hist      <= btn;
            rst_q     <= 1'b0;
            ms_up_q   <= ms_up_n;
            field     <= field_n;
            blink     <= blink_n;
            blink_cnt <= blink_cnt_n;
            rep_act   <= rep_act_n;
            rep_dir   <= rep_dir_n;
            rep_rpt   <= rep_rpt_n;
            rep_cnt   <= rep_cnt_n;
            up_q      <= up_n;
            down_q    <= down_n;
        end
    end

    assign o_ms_up    = live & ms_up_q;
    assign o_ms_down  = 1'b0;
    assign o_sec_up   = live & ((run & i_ms_carryup) | up_q[0]);
    assign o_sec_down = live & down_q[0];
    assign o_min_up   = live & ((run & i_sec_carryup) | up_q[1]);
    assign o_min_down = live & down_q[1];
    assign o_hr_up    = live & ((run & i_min_carryup) | up_q[2]);
    assign o_hr_down  = live & down_q[2];
    assign o_set_mode = state == SET;
    assign o_field    = field;
    assign o_blink    = blink;
endmodule

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer: directed checks of timebase, cascade, cursor, edit pulses, auto-repeat and reset
module tb_clock_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = 5'b00000;
    logic       ms_c = 1'b0, sec_c = 1'b0, min_c = 1'b0;
    logic       ms_up, ms_down, sec_up, sec_down, min_up, min_down, hr_up, hr_down;
    logic       set_mode, blink;
    logic [1:0] field;
    logic [7:0] steps;
    int         checks = 0;
    int         errors = 0;

    localparam logic [4:0] B_SET = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100, B_L = 5'b00010, B_R = 5'b00001;

    clock_sequencer #(.TICK_DIV(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .BLINK_HALF(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_set(btn[4]), .i_up(btn[3]), .i_down(btn[2]), .i_left(btn[1]), .i_right(btn[0]),
        .i_ms_carryup(ms_c), .i_sec_carryup(sec_c), .i_min_carryup(min_c),
        .o_ms_up(ms_up), .o_ms_down(ms_down), .o_sec_up(sec_up), .o_sec_down(sec_down),
        .o_min_up(min_up), .o_min_down(min_down), .o_hr_up(hr_up), .o_hr_down(hr_down),
        .o_set_mode(set_mode), .o_field(field), .o_blink(blink)
    );

    assign steps = {hr_down, hr_up, min_down, min_up, sec_down, sec_up, ms_down, ms_up};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tic();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tap(input logic [4:0] b);
        btn = b;
        tic();
        btn = 5'b00000;
        tic();
    endtask

    initial begin
        btn = B_UP;
        repeat (3) tic();
        chk("rst_steps", steps, 8'h00);
        chk("rst_mode", {7'd0, set_mode}, 8'h00);
        chk("rst_field", {6'd0, field}, 8'h00);
        chk("rst_blink", {7'd0, blink}, 8'h00);
        rst = 1'b0;
        #1;
        chk("post_rst_steps", steps, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            tic();
            chk($sformatf("run_ms_%0d", k), steps, (k % 4 == 0) ? 8'h01 : 8'h00);
            chk("run_mode", {7'd0, set_mode}, 8'h00);
        end
        ms_c = 1'b1;
        #1;
        chk("cascade_sec_up", {7'd0, sec_up}, 8'h01);
        chk("cascade_min_up", {7'd0, min_up}, 8'h00);
        ms_c = 1'b0;
        tic();
        chk("cascade_clear", steps, 8'h00);
        btn = B_SET;
        tic();
        chk("set_mode", {7'd0, set_mode}, 8'h01);
        chk("set_field", {6'd0, field}, 8'h00);
        chk("set_blink", {7'd0, blink}, 8'h01);
        btn = 5'b00000;
        repeat (7) tic();
        chk("blink_hold", {7'd0, blink}, 8'h01);
        tic();
        chk("blink_toggle", {7'd0, blink}, 8'h00);
        tap(B_R);
        chk("right_1", {6'd0, field}, 8'h01);
        tap(B_R);
        chk("right_2", {6'd0, field}, 8'h02);
        tap(B_R);
        chk("right_0", {6'd0, field}, 8'h00);
        tap(B_L);
        chk("left_2", {6'd0, field}, 8'h02);
        tap(B_L | B_R);
        chk("left_right", {6'd0, field}, 8'h02);
        tap(B_L);
        chk("left_1", {6'd0, field}, 8'h01);
        btn = B_UP;
        tic();
        chk("min_up_pulse", steps, 8'h10);
        btn = 5'b00000;
        tic();
        chk("min_up_single", steps, 8'h00);
        ms_c = 1'b1;
        sec_c = 1'b1;
        min_c = 1'b1;
        #1;
        chk("set_carry_blocked", steps, 8'h00);
        ms_c = 1'b0;
        sec_c = 1'b0;
        min_c = 1'b0;
        tap(B_SET);
        chk("leave_mode", {7'd0, set_mode}, 8'h00);
        chk("leave_field", {6'd0, field}, 8'h01);
        chk("leave_blink", {7'd0, blink}, 8'h00);
        btn = B_SET;
        tic();
        chk("reenter_field", {6'd0, field}, 8'h00);
        btn = B_DN;
        for (int n = 1; n <= 48; n++) begin
            tic();
            chk($sformatf("repeat_%0d", n), steps,
                (n == 1 || n == 12 || n == 20 || n == 28 || n == 36) ? 8'h08 : 8'h00);
            if (n == 40) btn = 5'b00000;
        end
        btn = B_SET | B_UP;
        tic();
        chk("set_up_mode", {7'd0, set_mode}, 8'h00);
        chk("set_up_steps", steps, 8'h00);
        btn = 5'b00000;
        tic();
        chk("set_up_after", steps, 8'h00);
        tap(B_SET);
        tap(B_R);
        btn = B_UP;
        repeat (14) tic();
        chk("pre_rst_mode", {7'd0, set_mode}, 8'h01);
        chk("pre_rst_field", {6'd0, field}, 8'h01);
        rst = 1'b1;
        tic();
        chk("mid_rst_steps", steps, 8'h00);
        chk("mid_rst_mode", {7'd0, set_mode}, 8'h00);
        chk("mid_rst_field", {6'd0, field}, 8'h00);
        chk("mid_rst_blink", {7'd0, blink}, 8'h00);
        rst = 1'b0;
        #1;
        chk("after_rst_steps", steps, 8'h00);
        repeat (3) tic();
        chk("held_up_no_press", steps, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
Timebase and mode sequencer for the wall-clock counter chain (ms 0..999, sec 0..59, min 0..59, hr 0..23).
- RUN mode: divides the system clock into a 1 ms up-pulse for the ms counter and cascades counter carries upward.
- SET mode: the user selects a field (sec/min/hr) with left/right and adjusts it with up/down, including auto-repeat. A blink flag is provided for the display.

Parameters:
- TICK_DIV, 50000, system clock cycles per 1 ms tick (>=2).
- REPEAT_DELAY, 500, ms ticks an up/down button must be held before auto-repeat starts.
- REPEAT_RATE, 100, ms ticks between auto-repeat pulses.
- BLINK_HALF, 250, ms ticks per half-period of o_blink.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_set  in  1  mode button, level, already synchronized/debounced.
- i_up  in  1  increment button, level.
- i_down  in  1  decrement button, level.
- i_left  in  1  cursor-left button, level.
- i_right  in  1  cursor-right button, level.
- i_ms_carryup  in  1  ms counter wrap 999->0, same cycle as its up pulse.
- i_sec_carryup  in  1  sec counter wrap 59->0, same cycle as its up pulse.
- i_min_carryup  in  1  min counter wrap 59->0, same cycle as its up pulse.
- o_ms_up, o_ms_down  out  1  ms counter step pulses.
- o_sec_up, o_sec_down  out  1  sec counter step pulses.
- o_min_up, o_min_down  out  1  min counter step pulses.
- o_hr_up, o_hr_down  out  1  hr counter step pulses.
- o_set_mode  out  1  1 = SET, 0 = RUN.
- o_field  out  2  selected field: 0 sec, 1 min, 2 hr (3 never driven).
- o_blink  out  1  display blink phase for the selected field.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset: mode RUN, o_field=0, o_blink=0, all step pulses 0, prescaler=0, repeat and blink counters 0. Button history registers load 1, so a button held through reset produces no press.
- Press detection: press = level 1 now AND history register 0. History updates every cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 continuously in both modes.
  - tick=1 for one cycle at TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on every mode change.
- FSM states RUN and SET. An i_set press toggles the state; it is registered, so the new state is visible the next cycle.
- Priority in the cycle of an i_set press: up/down/left/right presses in that cycle are ignored.
- RUN:
  - o_ms_up is a registered copy of tick: 1-cycle pulse, one cycle after the prescaler terminal count.
  - o_sec_up = i_ms_carryup, o_min_up = i_sec_carryup, o_hr_up = i_min_carryup. These cascade paths are combinational and gated by RUN.
  - All *_down outputs are 0. left/right/up/down are ignored.
- SET:
  - o_ms_up is held 0 and carries are ignored, so editing sec never alters min.
- Entering SET: o_field=0, o_blink=1, blink counter=0, repeat state idle.
- Cursor:
  - right press: field 0->1->2->0.
  - left press: field 0->2->1->0.
  - left and right pressed in the same cycle: no move.
  - A field change resets the repeat state to idle.
- Adjust:
  - An up press gives one registered 1-cycle *_up pulse on the selected field (latency 1 cycle); down likewise with *_down.
  - Up and down both at level 1: no pulse, repeat state idle.
- Auto-repeat (per held button):
  - Holding counter starts at 0 on the press and increments on each tick.
  - When it reaches REPEAT_DELAY: one extra pulse. After that, one pulse every REPEAT_RATE ticks while the button is still held.
  - Release returns the repeat state to idle.
- Blink: o_blink toggles every BLINK_HALF ticks in SET. Forced 0 in RUN.
- Leaving SET: o_field retained and o_blink=0. Timekeeping resumes from ms=current value with the prescaler cleared.
- Reset asserted mid-operation (in any state, including mid-repeat) restores the full reset state on the next edge. No pulse is emitted in the reset cycle or the cycle after it.
- Every step output is high for at most one cycle. Never is both up and down of the same counter high.

Test Plan:
- Reset with i_up held, release reset, keep i_up held: no pulses, o_set_mode=0, o_field=0, o_blink=0.
- RUN with TICK_DIV=4: o_ms_up pulses every 4 cycles. Drive i_ms_carryup=1 for one cycle: o_sec_up=1 in that same cycle, o_min_up=0.
- i_set press -> SET with o_field=0. right, right, right presses -> o_field goes 1, 2, 0. left press -> 2. left and right together -> unchanged.
- SET, field=1, single up press -> exactly one o_min_up pulse, one cycle after the press. i_min_carryup pulsed -> o_hr_up stays 0.
- SET, TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2, hold i_down for 40 cycles -> o_sec_down pulses at the press, after 3 ticks, then every 2 ticks. Release -> pulses stop.
- i_set press in the same cycle as i_up in SET -> returns to RUN with no o_*_up edit pulse. Assert i_rst mid-repeat -> all outputs 0 on the next edge.
